// File: rtl/braille_decoder.sv
// Grade-1 braille cell to ASCII decoder writing a 0x00-terminated byte buffer.
// Define BRAILLE_PUNCT_EN to add the punctuation decodes.
module braille_decoder #(
    parameter int         ADDR_W      = 8,
    parameter int         MEM_DEPTH   = 256,
    parameter logic [7:0] UNKNOWN_CHR = 8'h3F
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cell_valid,
    input  logic [5:0]        cell_in,
    output logic              cell_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_we,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {ACCEPT, WRITE, DONE} state_t;

    localparam logic [5:0] CELL_CAP   = 6'b100000;
    localparam logic [5:0] CELL_NUM   = 6'b111100;
    localparam logic [5:0] CELL_END   = 6'b111111;
    localparam logic [5:0] CELL_SPACE = 6'b000000;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    state_t     state;
    logic       cap;
    logic       num;
    logic       term;
    logic [7:0] letter;
    logic [7:0] punct;
    logic [7:0] chr;
    logic       chr_err;
    logic       chr_num;
    logic       is_letter;
    logic       is_digit;

    always_comb begin
        letter = 8'h00;
        case (cell_in)
            6'b000001: letter = "a";
            6'b000011: letter = "b";
            6'b001001: letter = "c";
            6'b011001: letter = "d";
            6'b010001: letter = "e";
            6'b001011: letter = "f";
            6'b011011: letter = "g";
            6'b010011: letter = "h";
            6'b001010: letter = "i";
            6'b011010: letter = "j";
            6'b000101: letter = "k";
            6'b000111: letter = "l";
            6'b001101: letter = "m";
            6'b011101: letter = "n";
            6'b010101: letter = "o";
            6'b001111: letter = "p";
            6'b011111: letter = "q";
            6'b010111: letter = "r";
            6'b001110: letter = "s";
            6'b011110: letter = "t";
            6'b100101: letter = "u";
            6'b100111: letter = "v";
            6'b111010: letter = "w";
            6'b101101: letter = "x";
            6'b111101: letter = "y";
            6'b110101: letter = "z";
            default:   letter = 8'h00;
        endcase
    end

    always_comb begin
        punct = 8'h00;
`ifdef BRAILLE_PUNCT_EN
        case (cell_in)
            6'b000010: punct = ",";
            6'b110010: punct = ".";
            6'b100110: punct = "?";
            6'b010110: punct = "!";
            6'b000100: punct = "'";
            6'b100100: punct = "-";
            default:   punct = 8'h00;
        endcase
`endif
    end

    assign is_letter = letter != 8'h00;
    assign is_digit  = is_letter && num && (letter <= "j");

    // a..i map to '1'..'9' by a fixed offset; j wraps to '0'
    always_comb begin
        chr     = UNKNOWN_CHR;
        chr_err = 1'b1;
        chr_num = num;
        unique case (1'b1)
            cell_in == CELL_SPACE: begin
                chr     = 8'h20;
                chr_err = 1'b0;
                chr_num = 1'b0;
            end
            is_digit: begin
                chr     = (letter == "j") ? "0" : letter - 8'h30;
                chr_err = 1'b0;
            end
            is_letter && !is_digit: begin
                chr     = cap ? letter - 8'h20 : letter;
                chr_err = 1'b0;
                chr_num = 1'b0;
            end
            punct != 8'h00: begin
                chr     = punct;
                chr_err = 1'b0;
                chr_num = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ACCEPT;
            cell_ready <= 1'b1;
            mem_addr   <= '0;
            mem_din    <= 8'h00;
            mem_we     <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cap        <= 1'b0;
            num        <= 1'b0;
            term       <= 1'b0;
        end else begin
            case (state)
                ACCEPT: begin
                    if (cell_valid) begin
                        if (cell_in == CELL_CAP) begin
                            cap <= 1'b1;
                        end else if (cell_in == CELL_NUM) begin
                            num <= 1'b1;
                            cap <= 1'b0;
                        end else begin
                            mem_we     <= 1'b1;
                            cell_ready <= 1'b0;
                            cap        <= 1'b0;
                            state      <= WRITE;
                            // last slot only ever holds the terminator
                            if (cell_in == CELL_END || mem_addr == LAST_ADDR) begin
                                mem_din <= 8'h00;
                                term    <= 1'b1;
                                if (cell_in != CELL_END) err <= 1'b1;
                            end else begin
                                mem_din <= chr;
                                num     <= chr_num;
                                if (chr_err) err <= 1'b1;
                            end
                        end
                    end
                end
                WRITE: begin
                    mem_we <= 1'b0;
                    if (term) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        mem_addr   <= mem_addr + 1'b1;
                        cell_ready <= 1'b1;
                        state      <= ACCEPT;
                    end
                end
                DONE: ;
                default: state <= ACCEPT;
            endcase
        end
    end

endmodule

// File: tb/tb_braille_decoder.sv
// Directed self-checking bench for braille_decoder (default and 4-byte instances).
module tb_braille_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       v0, v1;
    logic [5:0] c0, c1;
    logic       rdy0, rdy1;
    logic [7:0] a0, a1;
    logic [7:0] d0, d1;
    logic       we0, we1;
    logic       done0, done1;
    logic       err0, err1;

    always #5 clk = ~clk;

    braille_decoder u_dut (
        .clk(clk), .reset(reset), .cell_valid(v0), .cell_in(c0),
        .cell_ready(rdy0), .mem_addr(a0), .mem_din(d0), .mem_we(we0),
        .done(done0), .err(err0)
    );

    braille_decoder #(.ADDR_W(8), .MEM_DEPTH(4)) u_small (
        .clk(clk), .reset(reset), .cell_valid(v1), .cell_in(c1),
        .cell_ready(rdy1), .mem_addr(a1), .mem_din(d1), .mem_we(we1),
        .done(done1), .err(err1)
    );

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_xfer = -10;
    int wr0 = 0;
    int wr1 = 0;
    int lat_bad = 0;
    int rdy_bad = 0;
    int bp_xfer = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (v0 && rdy0) begin
            last_xfer <= cyc;
            if (c0 != 6'b100000 && c0 != 6'b111100) bp_xfer <= bp_xfer + 1;
        end
        if (we0) begin
            mem0[a0] <= d0;
            wr0 <= wr0 + 1;
            if (cyc != last_xfer + 1) lat_bad <= lat_bad + 1;
            if (rdy0) rdy_bad <= rdy_bad + 1;
        end
        if (we1) begin
            mem1[a1] <= d1;
            wr1 <= wr1 + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        v0 = 1'b0;
        v1 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send(input int d, input logic [5:0] c);
        int n;
        n = 0;
        @(negedge clk);
        while (((d == 0) ? !rdy0 : !rdy1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", (d == 0) ? rdy0 : rdy1, 1);
        if (d == 0) begin
            c0 = c;
            v0 = 1'b1;
        end else begin
            c1 = c;
            v1 = 1'b1;
        end
        @(posedge clk);
        #1;
        v0 = 1'b0;
        v1 = 1'b0;
    endtask

    task automatic wait_done(input int d, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (((d == 0) ? !done0 : !done1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, (d == 0) ? done0 : done1, 1);
    endtask

    int base_w;
    int base_b;
    int base_r;

    initial begin
        reset = 1'b1;
        v0 = 1'b0;
        v1 = 1'b0;
        c0 = 6'b0;
        c1 = 6'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_ready", rdy0, 1);
        check("rst_addr", a0, 0);
        check("rst_din", d0, 0);
        check("rst_we", we0, 0);
        check("rst_done", done0, 0);
        check("rst_err", err0, 0);

        // "Hi"
        base_w = wr0;
        send(0, 6'b100000);
        send(0, 6'b010011);
        send(0, 6'b001010);
        send(0, 6'b111111);
        wait_done(0, "hi_done");
        check("hi_m0", mem0[0], 8'h48);
        check("hi_m1", mem0[1], 8'h69);
        check("hi_m2", mem0[2], 8'h00);
        check("hi_err", err0, 0);
        check("hi_writes", wr0 - base_w, 3);
        check("hi_latency", lat_bad, 0);
        check("hi_ready_after_done", rdy0, 0);

        // "12 c"
        do_reset();
        base_w = wr0;
        send(0, 6'b111100);
        send(0, 6'b000001);
        send(0, 6'b000011);
        send(0, 6'b000000);
        send(0, 6'b001001);
        send(0, 6'b111111);
        wait_done(0, "num_done");
        check("num_m0", mem0[0], 8'h31);
        check("num_m1", mem0[1], 8'h32);
        check("num_m2", mem0[2], 8'h20);
        check("num_m3", mem0[3], 8'h63);
        check("num_m4", mem0[4], 8'h00);
        check("num_addr", a0, 4);
        check("num_err", err0, 0);
        check("num_writes", wr0 - base_w, 5);

        // k-z after number sign, repeated capital sign
        do_reset();
        send(0, 6'b111100);
        send(0, 6'b000101);
        send(0, 6'b100000);
        send(0, 6'b100000);
        send(0, 6'b111010);
        send(0, 6'b111111);
        wait_done(0, "kw_done");
        check("kw_m0", mem0[0], 8'h6B);
        check("kw_m1", mem0[1], 8'h57);
        check("kw_m2", mem0[2], 8'h00);
        check("kw_err", err0, 0);

        // unknown cell
        do_reset();
        send(0, 6'b100001);
        send(0, 6'b111111);
        wait_done(0, "unk_done");
        check("unk_m0", mem0[0], 8'h3F);
        check("unk_m1", mem0[1], 8'h00);
        check("unk_err", err0, 1);

        // punctuation pattern '.'
        do_reset();
        send(0, 6'b110010);
        send(0, 6'b111111);
        wait_done(0, "punct_done");
`ifdef BRAILLE_PUNCT_EN
        check("punct_m0", mem0[0], 8'h2E);
        check("punct_err", err0, 0);
`else
        check("punct_m0", mem0[0], 8'h3F);
        check("punct_err", err0, 1);
`endif

        // overflow on the 4-byte instance
        do_reset();
        send(1, 6'b000001);
        send(1, 6'b000011);
        send(1, 6'b001001);
        send(1, 6'b011001);
        wait_done(1, "ovf_done");
        base_w = wr1;
        @(negedge clk);
        c1 = 6'b010001;
        v1 = 1'b1;
        repeat (10) @(negedge clk);
        check("ovf_ready", rdy1, 0);
        check("ovf_no_write", wr1 - base_w, 0);
        v1 = 1'b0;
        check("ovf_m0", mem1[0], 8'h61);
        check("ovf_m1", mem1[1], 8'h62);
        check("ovf_m2", mem1[2], 8'h63);
        check("ovf_m3", mem1[3], 8'h00);
        check("ovf_err", err1, 1);
        check("ovf_addr", a1, 3);

        // reset during WRITE
        do_reset();
        send(0, 6'b111100);
        send(0, 6'b000001);
        check("rw_we_before", we0, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rw_we_after", we0, 0);
        check("rw_addr", a0, 0);
        check("rw_ready", rdy0, 1);
        base_w = wr0;
        send(0, 6'b000001);
        send(0, 6'b111111);
        wait_done(0, "rw_done");
        check("rw_m0", mem0[0], 8'h61);
        check("rw_m1", mem0[1], 8'h00);
        check("rw_writes", wr0 - base_w, 2);

        // valid held high with random non-end cells
        do_reset();
        base_w = wr0;
        base_b = bp_xfer;
        base_r = rdy_bad;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            c0 = 6'($urandom_range(0, 62));
            v0 = 1'b1;
        end
        @(negedge clk);
        v0 = 1'b0;
        repeat (3) @(negedge clk);
        check("rnd_writes", wr0 - base_w, bp_xfer - base_b);
        check("rnd_ready_low_in_write", rdy_bad - base_r, 0);
        check("rnd_enough_xfers", (bp_xfer - base_b) >= 8, 1);
        check("rnd_latency", lat_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
